mem_bus_arbiter: RTL and testbench

- Shares the single external memory bus between three requesters:
  - Icache line refill (IC).
  - Dcache line refill or writeback (DC).
  - Uncached/MMIO single-word access issued by the MEM stage through bc (UN).
- Arbitrates only when idle; once granted, a transfer owns the bus until its last beat.
- Sequences burst beats: address generation and beat counting.
- Returns per-beat ready/data to the owner and raises busy toward the flow controller.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_pick.sv | 41 ++++
 rtl/mem_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the external memory bus arbiter.
// The optional MEM_ARB_RR_EN build switches arbitration to round-robin.
package mem_arb_pkg;

    localparam int unsigned BURST_LEN_DEF = 4;
    localparam int unsigned WORD_BYTES    = 4;

    // Bit positions inside the {UN, DC, IC} request vector
    localparam int unsigned REQ_IC = 0;
    localparam int unsigned REQ_DC = 1;
    localparam int unsigned REQ_UN = 2;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IC   = 2'd1,
        GNT_DC   = 2'd2,
        GNT_UN   = 2'd3
    } grant_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select over the {UN, DC, IC} request vector.
// MEM_ARB_RR_EN: round-robin starting after the last winner; otherwise fixed DC > UN > IC.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [2:0] req_i,
`ifdef MEM_ARB_RR_EN
    input  grant_e     last_i,
`endif
    output grant_e     win_o
);

    always_comb begin
        win_o = GNT_NONE;
`ifdef MEM_ARB_RR_EN
        // Rotation order is IC -> DC -> UN -> IC
        case (last_i)
            GNT_DC: begin
                if      (req_i[REQ_UN]) win_o = GNT_UN;
                else if (req_i[REQ_IC]) win_o = GNT_IC;
                else if (req_i[REQ_DC]) win_o = GNT_DC;
            end
            GNT_UN: begin
                if      (req_i[REQ_IC]) win_o = GNT_IC;
                else if (req_i[REQ_DC]) win_o = GNT_DC;
                else if (req_i[REQ_UN]) win_o = GNT_UN;
            end
            default: begin
                if      (req_i[REQ_DC]) win_o = GNT_DC;
                else if (req_i[REQ_UN]) win_o = GNT_UN;
                else if (req_i[REQ_IC]) win_o = GNT_IC;
            end
        endcase
`else
        if      (req_i[REQ_DC]) win_o = GNT_DC;
        else if (req_i[REQ_UN]) win_o = GNT_UN;
        else if (req_i[REQ_IC]) win_o = GNT_IC;
`endif
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the external memory bus between Icache, Dcache and uncached requesters,
// sequencing line bursts. MEM_ARB_RR_EN selects round-robin arbitration.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned BURST_LEN = BURST_LEN_DEF,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ic_req_i,
    input  logic [AW-1:0] ic_addr_i,
    output logic          ic_ready_o,
    input  logic          dc_req_i,
    input  logic          dc_we_i,
    input  logic [AW-1:0] dc_addr_i,
    input  logic [DW-1:0] dc_wdata_i,
    output logic          dc_ready_o,
    input  logic          un_req_i,
    input  logic          un_we_i,
    input  logic [AW-1:0] un_addr_i,
    input  logic [DW-1:0] un_wdata_i,
    output logic          un_ready_o,
    output logic [DW-1:0] arb_rdata_o,
    output logic          arb_busy_o,
    output logic [1:0]    arb_grant_o,
    output logic          bus_req_o,
    output logic          bus_we_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [DW-1:0] bus_wdata_o,
    input  logic          bus_ack_i,
    input  logic [DW-1:0] bus_rdata_i
);

    localparam int unsigned   CW        = $clog2(BURST_LEN);
    localparam logic [AW-1:0] LINE_MASK = ~AW'(BURST_LEN * WORD_BYTES - 1);

    state_e        state_q, state_d;
    grant_e        grant_q, grant_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [AW-1:0] base_q,  base_d;
    logic          we_q,    we_d;
    grant_e        win;
    logic [CW-1:0] last_beat;
    logic          xfer;
    logic          beat;

`ifdef MEM_ARB_RR_EN
    grant_e        last_q, last_d;

    mem_arb_pick u_pick (
        .req_i  ({un_req_i, dc_req_i, ic_req_i}),
        .last_i (last_q),
        .win_o  (win)
    );
`else
    mem_arb_pick u_pick (
        .req_i  ({un_req_i, dc_req_i, ic_req_i}),
        .win_o  (win)
    );
`endif

    assign last_beat = (grant_q == GNT_UN) ? '0 : CW'(BURST_LEN - 1);
    assign xfer      = (state_q == ST_XFER);
    assign beat      = xfer && bus_ack_i;

    // State and transfer context registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= GNT_NONE;
            cnt_q   <= '0;
            base_q  <= '0;
            we_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q  <= GNT_IC;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            we_q    <= we_d;
`ifdef MEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    // Arbitration, beat counting and DONE turnaround
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        we_d    = we_q;
`ifdef MEM_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win != GNT_NONE) begin
                    state_d = ST_XFER;
                    grant_d = win;
                    cnt_d   = '0;
`ifdef MEM_ARB_RR_EN
                    last_d  = win;
`endif
                    case (win)
                        GNT_DC: begin
                            base_d = dc_addr_i & LINE_MASK;
                            we_d   = dc_we_i;
                        end
                        GNT_UN: begin
                            base_d = un_addr_i;
                            we_d   = un_we_i;
                        end
                        default: begin
                            base_d = ic_addr_i & LINE_MASK;
                            we_d   = 1'b0;
                        end
                    endcase
                end
            end
            ST_XFER: begin
                if (bus_ack_i) begin
                    if (cnt_q == last_beat) state_d = ST_DONE;
                    else                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

    assign arb_busy_o  = (state_q != ST_IDLE);
    assign arb_grant_o = grant_q;
    assign bus_req_o   = xfer;
    assign bus_we_o    = xfer && we_q;
    assign bus_addr_o  = xfer ? (base_q + AW'(cnt_q) * AW'(WORD_BYTES)) : '0;
    assign ic_ready_o  = beat && (grant_q == GNT_IC);
    assign dc_ready_o  = beat && (grant_q == GNT_DC);
    assign un_ready_o  = beat && (grant_q == GNT_UN);
    assign arb_rdata_o = beat ? bus_rdata_i : '0;

    // Write data follows the owner so Dcache can advance its beat on dc_ready_o
    always_comb begin
        bus_wdata_o = '0;
        if (xfer && we_q) begin
            case (grant_q)
                GNT_DC:  bus_wdata_o = dc_wdata_i;
                GNT_UN:  bus_wdata_o = un_wdata_i;
                default: bus_wdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed requester steps, a bus responder
// with programmable ack latency, and per-beat checks against queued expectations.
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned BL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ic_req_i, dc_req_i, dc_we_i, un_req_i, un_we_i;
    logic [31:0] ic_addr_i, dc_addr_i, un_addr_i, un_wdata_i, dc_wdata_i;
    logic        ic_ready_o, dc_ready_o, un_ready_o;
    logic [31:0] arb_rdata_o, bus_addr_o, bus_wdata_o;
    logic        arb_busy_o, bus_req_o, bus_we_o;
    logic [1:0]  arb_grant_o;
    logic        bus_ack_i = 1'b0;
    logic [31:0] bus_rdata_i = 32'h1234_5678;

    typedef struct {
        logic [1:0]  gnt;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    beat_t       sb[$];
    beat_t       mon_e;
    int          checks = 0;
    int          failures = 0;
    int          req_cycles = 1;
    int          wait_cnt = 0;
    logic        force_ack = 1'b0;
    int          busy_cnt = 0;
    int          req_cnt = 0;
    int          dc_idx = 0;
    logic [31:0] dc_wbase = 32'h0;
    logic [1:0]  last_g;

    assign dc_wdata_i = dc_wbase + 32'(dc_idx);

    always #5 clk = ~clk;

    mem_bus_arbiter #(.BURST_LEN(BL), .AW(32), .DW(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ic_req_i    (ic_req_i),
        .ic_addr_i   (ic_addr_i),
        .ic_ready_o  (ic_ready_o),
        .dc_req_i    (dc_req_i),
        .dc_we_i     (dc_we_i),
        .dc_addr_i   (dc_addr_i),
        .dc_wdata_i  (dc_wdata_i),
        .dc_ready_o  (dc_ready_o),
        .un_req_i    (un_req_i),
        .un_we_i     (un_we_i),
        .un_addr_i   (un_addr_i),
        .un_wdata_i  (un_wdata_i),
        .un_ready_o  (un_ready_o),
        .arb_rdata_o (arb_rdata_o),
        .arb_busy_o  (arb_busy_o),
        .arb_grant_o (arb_grant_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rdy(input logic [1:0] g);
        case (g)
            2'd1:    return 32'd1;
            2'd2:    return 32'd2;
            2'd3:    return 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    task automatic push_burst(input logic [1:0] g, input logic we, input logic [31:0] base,
                              input int n, input logic [31:0] wbase);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.gnt   = g;
            b.we    = we;
            b.addr  = base + 32'(4 * i);
            b.wdata = wbase + 32'(i);
            sb.push_back(b);
        end
    endtask

    task automatic wait_sb(input int n, input string tag);
        int k = 0;
        while (sb.size() > n && k < 300) begin
            @(negedge clk); #2;
            k++;
        end
        check({tag, "_wait"}, 32'(sb.size() <= n), 32'd1);
    endtask

    // Called in the last XFER cycle: expect one DONE turnaround, then IDLE
    task automatic finish_xfer(input logic [1:0] g, input string tag);
        @(negedge clk); #2;
        check({tag, "_done_req"},   32'(bus_req_o),   32'd0);
        check({tag, "_done_grant"}, 32'(arb_grant_o), 32'(g));
        check({tag, "_done_busy"},  32'(arb_busy_o),  32'd1);
        @(negedge clk); #2;
        check({tag, "_idle_busy"},  32'(arb_busy_o),  32'd0);
        check({tag, "_idle_grant"}, 32'(arb_grant_o), 32'd0);
    endtask

    // Bus responder plus beat monitor
    always @(negedge clk) begin
        if (bus_req_o) begin
            if (wait_cnt >= req_cycles - 1) begin
                bus_ack_i = 1'b1;
                wait_cnt  = 0;
            end else begin
                bus_ack_i = 1'b0;
                wait_cnt++;
            end
        end else begin
            bus_ack_i = force_ack;
            wait_cnt  = 0;
        end
        bus_rdata_i = bus_addr_o ^ 32'hA5A5_0000;
        #1;
        if (arb_busy_o) busy_cnt++;
        if (bus_req_o)  req_cnt++;
        if (bus_req_o && bus_ack_i) begin
            check("beat_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("beat_grant", 32'(arb_grant_o), 32'(mon_e.gnt));
                check("beat_we",    32'(bus_we_o),    32'(mon_e.we));
                check("beat_addr",  bus_addr_o,       mon_e.addr);
                check("beat_rdata", arb_rdata_o,      mon_e.addr ^ 32'hA5A5_0000);
                check("beat_ready", {29'd0, un_ready_o, dc_ready_o, ic_ready_o}, exp_rdy(mon_e.gnt));
                if (mon_e.we) check("beat_wdata", bus_wdata_o, mon_e.wdata);
            end
            if (dc_ready_o) dc_idx++;
        end else begin
            check("no_beat_ready", {29'd0, un_ready_o, dc_ready_o, ic_ready_o}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        ic_req_i = 0; dc_req_i = 0; un_req_i = 0; dc_we_i = 0; un_we_i = 0;
        ic_addr_i = 32'h0; dc_addr_i = 32'h0;
        un_addr_i = 32'h55AA_55AA; un_wdata_i = 32'hFFFF_0000;
        dc_wbase = 32'h0BAD_0000;

        // Reset values with noisy inputs
        #1;
        check("rst_bus_req",   32'(bus_req_o),   32'd0);
        check("rst_bus_we",    32'(bus_we_o),    32'd0);
        check("rst_bus_addr",  bus_addr_o,       32'd0);
        check("rst_bus_wdata", bus_wdata_o,      32'd0);
        check("rst_rdata",     arb_rdata_o,      32'd0);
        check("rst_busy",      32'(arb_busy_o),  32'd0);
        check("rst_grant",     32'(arb_grant_o), 32'd0);
        check("rst_ready",     {29'd0, un_ready_o, dc_ready_o, ic_ready_o}, 32'd0);
        @(negedge clk); @(negedge clk); #2;
        rst_n = 1;
        @(negedge clk); #2;

        // IC refill, unaligned miss address
        busy_cnt = 0; req_cnt = 0;
        push_burst(GNT_IC, 1'b0, 32'h0000_1030, BL, 32'h0);
        ic_addr_i = 32'h0000_1034; ic_req_i = 1;
        wait_sb(0, "ic");
        ic_req_i = 0;
        finish_xfer(GNT_IC, "ic");
        check("ic_busy_cycles", 32'(busy_cnt), 32'(BL + 1));
        check("ic_req_cycles",  32'(req_cnt),  32'(BL));

        // Same-cycle IC + DC writeback: DC first, IC after the turnaround
        dc_idx = 0; dc_wbase = 32'hD0D0_0000; dc_addr_i = 32'h0000_2000; dc_we_i = 1;
        ic_addr_i = 32'h0000_3008;
        push_burst(GNT_DC, 1'b1, 32'h0000_2000, BL, 32'hD0D0_0000);
        push_burst(GNT_IC, 1'b0, 32'h0000_3000, BL, 32'h0);
        dc_req_i = 1; ic_req_i = 1;
        wait_sb(BL, "tie_dc");
        dc_req_i = 0;
        finish_xfer(GNT_DC, "tie_dc");
        wait_sb(0, "tie_ic");
        ic_req_i = 0;
        finish_xfer(GNT_IC, "tie_ic");

`ifdef MEM_ARB_RR_EN
        // After a DC win, the next IC + DC tie goes to IC
        dc_we_i = 0; dc_addr_i = 32'h0000_2040;
        push_burst(GNT_DC, 1'b0, 32'h0000_2040, BL, 32'h0);
        dc_req_i = 1;
        wait_sb(0, "rr_dc");
        dc_req_i = 0;
        finish_xfer(GNT_DC, "rr_dc");
        push_burst(GNT_IC, 1'b0, 32'h0000_3000, BL, 32'h0);
        push_burst(GNT_DC, 1'b0, 32'h0000_2040, BL, 32'h0);
        ic_req_i = 1; dc_req_i = 1;
        wait_sb(BL, "rr_tie_ic");
        ic_req_i = 0;
        finish_xfer(GNT_IC, "rr_tie_ic");
        wait_sb(0, "rr_tie_dc");
        dc_req_i = 0;
        finish_xfer(GNT_DC, "rr_tie_dc");
`endif

        // Uncached store, single beat with slow ack
        req_cycles = 5; busy_cnt = 0; req_cnt = 0;
        un_addr_i = 32'h1000_0006; un_we_i = 1; un_wdata_i = 32'hCAFE_F00D;
        push_burst(GNT_UN, 1'b1, 32'h1000_0006, 1, 32'hCAFE_F00D);
        un_req_i = 1;
        wait_sb(0, "un");
        un_req_i = 0;
        finish_xfer(GNT_UN, "un");
        check("un_req_cycles",  32'(req_cnt),  32'd5);
        check("un_busy_cycles", 32'(busy_cnt), 32'd6);
        req_cycles = 1;

        // Stray ack while idle has no effect
        force_ack = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #2;
            check("stray_busy",  32'(arb_busy_o), 32'd0);
            check("stray_rdata", arb_rdata_o,     32'd0);
        end
        force_ack = 0;

        // Reset after two of four DC writeback beats
        dc_idx = 0; dc_wbase = 32'hBEEF_0000; dc_addr_i = 32'h0000_401C; dc_we_i = 1;
        push_burst(GNT_DC, 1'b1, 32'h0000_4010, BL, 32'hBEEF_0000);
        dc_req_i = 1;
        wait_sb(2, "rst_dc");
        rst_n = 0; dc_req_i = 0;
        #1;
        check("mid_rst_bus_req",  32'(bus_req_o),   32'd0);
        check("mid_rst_grant",    32'(arb_grant_o), 32'd0);
        check("mid_rst_busy",     32'(arb_busy_o),  32'd0);
        check("mid_rst_dc_ready", 32'(dc_ready_o),  32'd0);
        check("mid_rst_addr",     bus_addr_o,       32'd0);
        sb.delete();
        @(negedge clk); @(negedge clk); #2;
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            check("post_rst_busy", 32'(arb_busy_o), 32'd0);
            check("post_rst_req",  32'(bus_req_o),  32'd0);
        end

        // IC drops its request after the first beat; burst still completes
        ic_addr_i = 32'h0000_500C;
        push_burst(GNT_IC, 1'b0, 32'h0000_5000, BL, 32'h0);
        ic_req_i = 1;
        wait_sb(BL - 1, "ic_drop_first");
        ic_req_i = 0;
        wait_sb(0, "ic_drop_rest");
        finish_xfer(GNT_IC, "ic_drop");

        // All three held: fixed priority starves IC, round-robin rotates
        dc_we_i = 0; dc_addr_i = 32'h0000_6000;
        un_we_i = 0; un_addr_i = 32'h2000_0010;
        ic_addr_i = 32'h0000_7000;
`ifdef MEM_ARB_RR_EN
        push_burst(GNT_DC, 1'b0, 32'h0000_6000, BL, 32'h0);
        push_burst(GNT_UN, 1'b0, 32'h2000_0010, 1,  32'h0);
        push_burst(GNT_IC, 1'b0, 32'h0000_7000, BL, 32'h0);
        last_g = GNT_IC;
`else
        for (int i = 0; i < 3; i++) push_burst(GNT_DC, 1'b0, 32'h0000_6000, BL, 32'h0);
        last_g = GNT_DC;
`endif
        ic_req_i = 1; dc_req_i = 1; un_req_i = 1;
        wait_sb(0, "starve");
        ic_req_i = 0; dc_req_i = 0; un_req_i = 0;
        finish_xfer(last_g, "starve");

        repeat (3) @(negedge clk);
        #2;
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        check("final_busy",     32'(arb_busy_o), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
